// File: rtl/new_task_acceptor_pkg.sv
// Shared constants, state/verdict encodings and header helpers for the
// new-task spawn receiver.
package new_task_acceptor_pkg;

  localparam int unsigned ID_W = 4;

  localparam int unsigned NUM_ARGS_OFFSET = 32;
  localparam int unsigned NUM_DEPS_OFFSET = 40;
  localparam int unsigned NUM_COPS_OFFSET = 48;

  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_FINAL_CODE  = 8'h02;

  localparam logic [ID_W-1:0] HWR_SCHED_ID = 4'hF;

  typedef enum logic [1:0] {
    VERDICT_OK,
    VERDICT_REJECT,
    VERDICT_FINAL,
    VERDICT_ERROR
  } verdict_t;

  typedef enum logic [1:0] {
    RX_HDR,
    RX_BODY,
    RX_DISCARD,
    SEND_ACK
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Malformed packets are answered with REJECT on the wire.
  function automatic logic [7:0] verdict_code(input verdict_t v);
    case (v)
      VERDICT_OK:    return ACK_OK_CODE;
      VERDICT_FINAL: return ACK_FINAL_CODE;
      default:       return ACK_REJECT_CODE;
    endcase
  endfunction

  function automatic logic [10:0] task_len(input logic [63:0] hdr);
    return 11'd3
         + {3'b000, hdr[NUM_DEPS_OFFSET +: 8]}
         + {2'b00, hdr[NUM_COPS_OFFSET +: 8], 1'b0}
         + {3'b000, hdr[NUM_ARGS_OFFSET +: 8]};
  endfunction

endpackage

// File: rtl/new_task_acceptor_slot_ram.sv
// Packet slot storage: NUM_SLOTS x SLOT_WORDS x 64, one synchronous write
// port and one combinational read port.
module new_task_slot_ram #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_WORDS = 32,
  localparam int unsigned AW = $clog2(NUM_SLOTS * SLOT_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [NUM_SLOTS * SLOT_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/new_task_acceptor.sv
// Receiver end of the new-task spawn protocol: validates, buffers and ACKs
// incoming task packets, then replays accepted ones to the scheduler.
module new_task_acceptor
  import new_task_acceptor_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_WORDS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                spawn_in_data,
  input  logic                       spawn_in_valid,
  output logic                       spawn_in_ready,
  input  logic [ID_W-1:0]            spawn_in_id,
  input  logic [ID_W-1:0]            spawn_in_dest,
  input  logic                       spawn_in_last,
  output logic [63:0]                spawn_ack_data,
  output logic                       spawn_ack_valid,
  input  logic                       spawn_ack_ready,
  output logic [ID_W-1:0]            spawn_ack_dest,
  output logic                       spawn_ack_last,
  output logic [63:0]                outStream_data,
  output logic                       outStream_valid,
  input  logic                       outStream_ready,
  output logic [ID_W-1:0]            outStream_id,
  output logic [ID_W-1:0]            outStream_dest,
  output logic                       outStream_last,
  input  logic                       final_mode,
  output logic [$clog2(NUM_SLOTS):0] free_slots,
  output logic                       proto_err
);

  localparam int unsigned PTR_W  = $clog2(NUM_SLOTS);
  localparam int unsigned OFF_W  = $clog2(SLOT_WORDS);
  localparam int unsigned LEN_W  = OFF_W + 1;
  localparam int unsigned FREE_W = PTR_W + 1;

  rx_state_t        rx_state;
  tx_state_t        tx_state;
  verdict_t         verdict;
  verdict_t         hdr_verdict;
  logic [10:0]      hdr_len;
  logic [LEN_W-1:0] rx_len;
  logic [LEN_W-1:0] rx_last_off;
  logic [OFF_W-1:0] wr_off;
  logic [OFF_W-1:0] rd_off;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FREE_W-1:0] committed;
  logic [7:0]       ack_code;
  logic [LEN_W-1:0] slot_len [NUM_SLOTS];
  logic [ID_W-1:0]  slot_id  [NUM_SLOTS];

  logic rx_fire, out_fire, at_end, tx_last;
  logic reserve, commit, release_slot, tx_free;
  logic ram_we;
  logic [OFF_W-1:0] ram_woff;
  logic unused_dest;

  assign unused_dest = ^spawn_in_dest;

  assign spawn_in_ready = !rst && (rx_state != SEND_ACK);
  assign rx_fire        = spawn_in_valid && spawn_in_ready;

  always_comb begin
    hdr_len = task_len(spawn_in_data);
    if (hdr_len > 11'(SLOT_WORDS) || spawn_in_last)
      hdr_verdict = VERDICT_ERROR;
    else if (free_slots == '0)
      hdr_verdict = VERDICT_REJECT;
    else if (final_mode && spawn_in_data[NUM_DEPS_OFFSET +: 8] != 8'd0)
      hdr_verdict = VERDICT_FINAL;
    else
      hdr_verdict = VERDICT_OK;
  end

  assign rx_last_off  = rx_len - LEN_W'(1);
  assign at_end       = ({1'b0, wr_off} == rx_last_off);
  assign reserve      = (rx_state == RX_HDR) && rx_fire && (hdr_verdict == VERDICT_OK);
  assign commit       = (rx_state == RX_BODY) && rx_fire && spawn_in_last && at_end;
  assign release_slot = (rx_state == RX_BODY) && rx_fire && (spawn_in_last != at_end);

  assign ram_we   = reserve || ((rx_state == RX_BODY) && rx_fire);
  assign ram_woff = (rx_state == RX_HDR) ? '0 : wr_off;

  new_task_slot_ram #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_WORDS(SLOT_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr({wr_ptr, ram_woff}),
    .wdata(spawn_in_data),
    .raddr({rd_ptr, rd_off}),
    .rdata(outStream_data)
  );

  // Receive FSM; ACK fields and proto_err are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state        <= RX_HDR;
      verdict         <= VERDICT_OK;
      rx_len          <= '0;
      wr_off          <= '0;
      spawn_ack_valid <= 1'b0;
      ack_code        <= '0;
      spawn_ack_dest  <= '0;
      proto_err       <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (rx_state)
        RX_HDR: begin
          if (rx_fire) begin
            spawn_ack_dest <= spawn_in_id;
            rx_len         <= LEN_W'(hdr_len);
            verdict        <= hdr_verdict;
            wr_off         <= OFF_W'(1);
            if (hdr_verdict == VERDICT_OK) begin
              rx_state <= RX_BODY;
            end else if (spawn_in_last) begin
              // Header already carried last: nothing left to drain.
              rx_state        <= SEND_ACK;
              spawn_ack_valid <= 1'b1;
              ack_code        <= verdict_code(hdr_verdict);
              proto_err       <= (hdr_verdict == VERDICT_ERROR);
            end else begin
              rx_state <= RX_DISCARD;
            end
          end
        end
        RX_BODY: begin
          if (rx_fire) begin
            wr_off <= wr_off + OFF_W'(1);
            if (spawn_in_last) begin
              rx_state        <= SEND_ACK;
              spawn_ack_valid <= 1'b1;
              ack_code        <= at_end ? ACK_OK_CODE : ACK_REJECT_CODE;
              proto_err       <= !at_end;
            end else if (at_end) begin
              rx_state  <= RX_DISCARD;
              verdict   <= VERDICT_REJECT;
              proto_err <= 1'b1;
            end
          end
        end
        RX_DISCARD: begin
          if (rx_fire && spawn_in_last) begin
            rx_state        <= SEND_ACK;
            spawn_ack_valid <= 1'b1;
            ack_code        <= verdict_code(verdict);
            proto_err       <= (verdict == VERDICT_ERROR);
          end
        end
        SEND_ACK: begin
          if (spawn_ack_ready) begin
            spawn_ack_valid <= 1'b0;
            rx_state        <= RX_HDR;
          end
        end
        default: rx_state <= RX_HDR;
      endcase
    end
  end

  assign spawn_ack_data = {56'd0, ack_code};
  assign spawn_ack_last = 1'b1;

  assign outStream_valid = (tx_state == TX_SEND);
  assign outStream_id    = slot_id[rd_ptr];
  assign outStream_dest  = HWR_SCHED_ID;
  assign tx_last         = ({1'b0, rd_off} == (slot_len[rd_ptr] - LEN_W'(1)));
  assign outStream_last  = outStream_valid && tx_last;
  assign out_fire        = outStream_valid && outStream_ready;
  assign tx_free         = out_fire && tx_last;

  // Slot ring bookkeeping and transmit FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_slots <= FREE_W'(NUM_SLOTS);
      committed  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_off     <= '0;
      tx_state   <= TX_IDLE;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_len[i] <= '0;
        slot_id[i]  <= '0;
      end
    end else begin
      free_slots <= free_slots - FREE_W'(reserve) + FREE_W'(release_slot) + FREE_W'(tx_free);
      committed  <= committed + FREE_W'(commit) - FREE_W'(tx_free);
      if (commit)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (tx_free) rd_ptr <= rd_ptr + PTR_W'(1);
      if (reserve) begin
        slot_len[wr_ptr] <= LEN_W'(hdr_len);
        slot_id[wr_ptr]  <= spawn_in_id;
      end
      case (tx_state)
        TX_IDLE: begin
          if (committed != '0) begin
            tx_state <= TX_SEND;
            rd_off   <= '0;
          end
        end
        TX_SEND: begin
          if (out_fire) begin
            if (tx_last) tx_state <= TX_IDLE;
            else         rd_off   <= rd_off + OFF_W'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_new_task_acceptor.sv
// Directed bench for new_task_acceptor: vector table of single packets plus
// sequences for slot exhaustion and mid-packet reset.
module tb_new_task_acceptor;
  import new_task_acceptor_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [63:0]     spawn_in_data;
  logic            spawn_in_valid;
  logic            spawn_in_ready;
  logic [ID_W-1:0] spawn_in_id;
  logic [ID_W-1:0] spawn_in_dest;
  logic            spawn_in_last;
  logic [63:0]     spawn_ack_data;
  logic            spawn_ack_valid;
  logic            spawn_ack_ready;
  logic [ID_W-1:0] spawn_ack_dest;
  logic            spawn_ack_last;
  logic [63:0]     outStream_data;
  logic            outStream_valid;
  logic            outStream_ready;
  logic [ID_W-1:0] outStream_id;
  logic [ID_W-1:0] outStream_dest;
  logic            outStream_last;
  logic            final_mode;
  logic [2:0]      free_slots;
  logic            proto_err;

  new_task_acceptor #(
    .NUM_SLOTS (4),
    .SLOT_WORDS(32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .spawn_in_data  (spawn_in_data),
    .spawn_in_valid (spawn_in_valid),
    .spawn_in_ready (spawn_in_ready),
    .spawn_in_id    (spawn_in_id),
    .spawn_in_dest  (spawn_in_dest),
    .spawn_in_last  (spawn_in_last),
    .spawn_ack_data (spawn_ack_data),
    .spawn_ack_valid(spawn_ack_valid),
    .spawn_ack_ready(spawn_ack_ready),
    .spawn_ack_dest (spawn_ack_dest),
    .spawn_ack_last (spawn_ack_last),
    .outStream_data (outStream_data),
    .outStream_valid(outStream_valid),
    .outStream_ready(outStream_ready),
    .outStream_id   (outStream_id),
    .outStream_dest (outStream_dest),
    .outStream_last (outStream_last),
    .final_mode     (final_mode),
    .free_slots     (free_slots),
    .proto_err      (proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned na, nd, nc;
    logic        fm;
    int unsigned n;
    logic [3:0]  id;
    logic [7:0]  code;
    int unsigned errs;
    logic        acc;
  } vec_t;

  typedef struct packed {
    logic        last;
    logic [3:0]  dest;
    logic [3:0]  id;
    logic [63:0] data;
  } beat_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned err_cnt = 0;
  logic [68:0] ack_q[$];
  beat_t       out_q[$];
  logic [63:0] w [64];
  logic [63:0] fw [4][8];
  vec_t        vecs [12];

  always @(negedge clk) begin
    if (!rst) begin
      if (spawn_ack_valid && spawn_ack_ready)
        ack_q.push_back({spawn_ack_last, spawn_ack_dest, spawn_ack_data});
      if (outStream_valid && outStream_ready)
        out_q.push_back({outStream_last, outStream_dest, outStream_id, outStream_data});
      if (proto_err) err_cnt++;
    end
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake.
  task automatic drive_word(input logic [63:0] d, input logic [3:0] id, input logic last);
    int unsigned t = 0;
    spawn_in_data  = d;
    spawn_in_id    = id;
    spawn_in_dest  = 4'h0;
    spawn_in_last  = last;
    spawn_in_valid = 1'b1;
    @(negedge clk);
    while (!spawn_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!spawn_in_ready) begin
      errors++;
      checks++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1;
    spawn_in_valid = 1'b0;
    spawn_in_last  = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned na, nd, nc, n, tag, input logic [3:0] id);
    logic [63:0] h;
    h = '0;
    h[NUM_ARGS_OFFSET +: 8] = 8'(na);
    h[NUM_DEPS_OFFSET +: 8] = 8'(nd);
    h[NUM_COPS_OFFSET +: 8] = 8'(nc);
    h[31:0] = {16'hC0DE, 16'(tag)};
    w[0] = h;
    for (int unsigned k = 1; k < 64; k++) w[k] = {16'hD00D, 16'(tag), 16'(k), 16'hA5A5};
    for (int unsigned k = 0; k < n; k++) drive_word(w[k], id, k == n - 1);
  endtask

  task automatic apply_vec(input vec_t v, input int unsigned tag);
    int unsigned ab, ob, eb, len, expn;
    ab = ack_q.size();
    ob = out_q.size();
    eb = err_cnt;
    final_mode = v.fm;
    len = 3 + v.nd + 2 * v.nc + v.na;
    send_pkt(v.na, v.nd, v.nc, v.n, tag, v.id);
    repeat (60) @(posedge clk);
    #1;
    check($sformatf("ack_count[%0d]", tag), 80'(ack_q.size() - ab), 80'd1);
    if (ack_q.size() > ab)
      check($sformatf("ack_word[%0d]", tag), 80'(ack_q[ab]), 80'({1'b1, v.id, 56'd0, v.code}));
    check($sformatf("proto_err[%0d]", tag), 80'(err_cnt - eb), 80'(v.errs));
    expn = v.acc ? len : 0;
    check($sformatf("out_count[%0d]", tag), 80'(out_q.size() - ob), 80'(expn));
    for (int unsigned k = 0; k < expn && ob + k < out_q.size(); k++)
      check($sformatf("out_beat[%0d.%0d]", tag, k), 80'(out_q[ob + k]),
            80'({k == len - 1, HWR_SCHED_ID, v.id, w[k]}));
    check($sformatf("free_slots[%0d]", tag), 80'(free_slots), 80'd4);
  endtask

  initial begin
    int unsigned ab, ob, eb;
    rst = 1'b1;
    spawn_in_data = '0; spawn_in_valid = 1'b0; spawn_in_id = '0;
    spawn_in_dest = '0; spawn_in_last = 1'b0;
    spawn_ack_ready = 1'b1; outStream_ready = 1'b1; final_mode = 1'b0;

    vecs[0]  = '{2,  1, 1, 1'b0, 8,  4'd3,  ACK_OK_CODE,     0, 1'b1};
    vecs[1]  = '{1,  2, 0, 1'b1, 6,  4'd4,  ACK_FINAL_CODE,  0, 1'b0};
    vecs[2]  = '{1,  0, 0, 1'b1, 4,  4'd4,  ACK_OK_CODE,     0, 1'b1};
    vecs[3]  = '{2,  1, 0, 1'b0, 4,  4'd5,  ACK_REJECT_CODE, 1, 1'b0};
    vecs[4]  = '{40, 0, 0, 1'b0, 45, 4'd6,  ACK_REJECT_CODE, 1, 1'b0};
    vecs[5]  = '{0,  0, 0, 1'b0, 3,  4'd7,  ACK_OK_CODE,     0, 1'b1};
    vecs[6]  = '{29, 0, 0, 1'b0, 32, 4'd8,  ACK_OK_CODE,     0, 1'b1};
    vecs[7]  = '{30, 0, 0, 1'b0, 33, 4'd9,  ACK_REJECT_CODE, 1, 1'b0};
    vecs[8]  = '{2,  1, 0, 1'b0, 8,  4'd10, ACK_REJECT_CODE, 1, 1'b0};
    vecs[9]  = '{0,  0, 0, 1'b0, 1,  4'd11, ACK_REJECT_CODE, 1, 1'b0};
    vecs[10] = '{0,  0, 2, 1'b1, 7,  4'd12, ACK_OK_CODE,     0, 1'b1};
    vecs[11] = '{40, 1, 0, 1'b1, 44, 4'd13, ACK_REJECT_CODE, 1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_free_slots", 80'(free_slots), 80'd4);
    check("rst_in_ready", 80'(spawn_in_ready), 80'd0);
    check("rst_ack_valid", 80'(spawn_ack_valid), 80'd0);
    check("rst_out_valid", 80'(outStream_valid), 80'd0);
    check("rst_proto_err", 80'(proto_err), 80'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // Slot exhaustion with the scheduler stalled.
    final_mode = 1'b0;
    outStream_ready = 1'b0;
    ab = ack_q.size(); ob = out_q.size(); eb = err_cnt;
    for (int unsigned p = 0; p < 4; p++) begin
      send_pkt(2, 0, 0, 5, 20 + p, 4'(p + 1));
      for (int unsigned k = 0; k < 5; k++) fw[p][k] = w[k];
    end
    repeat (5) @(posedge clk);
    #1;
    check("fill_free_slots", 80'(free_slots), 80'd0);
    send_pkt(2, 0, 0, 5, 24, 4'd5);
    repeat (5) @(posedge clk);
    #1;
    check("fill_ack_count", 80'(ack_q.size() - ab), 80'd5);
    for (int unsigned p = 0; p < 5 && ab + p < ack_q.size(); p++)
      check($sformatf("fill_ack[%0d]", p), 80'(ack_q[ab + p]),
            80'({1'b1, 4'(p + 1), 56'd0, (p < 4) ? ACK_OK_CODE : ACK_REJECT_CODE}));
    check("fill_proto_err", 80'(err_cnt - eb), 80'd0);
    check("fill_no_out", 80'(out_q.size() - ob), 80'd0);
    check("fill_free_after_reject", 80'(free_slots), 80'd0);
    outStream_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("drain_count", 80'(out_q.size() - ob), 80'd20);
    for (int unsigned b = 0; b < 20 && ob + b < out_q.size(); b++)
      check($sformatf("drain_beat[%0d]", b), 80'(out_q[ob + b]),
            80'({(b % 5) == 4, HWR_SCHED_ID, 4'(b / 5 + 1), fw[b / 5][b % 5]}));
    check("drain_free_slots", 80'(free_slots), 80'd4);

    // Reset in the middle of a packet with one slot committed.
    outStream_ready = 1'b0;
    send_pkt(2, 0, 0, 5, 30, 4'd6);
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_free_slots", 80'(free_slots), 80'd3);
    ab = ack_q.size(); ob = out_q.size();
    for (int unsigned k = 0; k < 3; k++) drive_word({48'hFACE, 16'(k)}, 4'd7, 1'b0);
    spawn_in_data  = 64'hFACE_0003;
    spawn_in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_free_slots", 80'(free_slots), 80'd4);
    check("mid_rst_in_ready", 80'(spawn_in_ready), 80'd0);
    check("mid_rst_ack_valid", 80'(spawn_ack_valid), 80'd0);
    check("mid_rst_out_valid", 80'(outStream_valid), 80'd0);
    check("mid_rst_proto_err", 80'(proto_err), 80'd0);
    @(posedge clk);
    #1;
    spawn_in_valid = 1'b0;
    rst = 1'b0;
    outStream_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_ack", 80'(ack_q.size() - ab), 80'd0);
    check("post_rst_no_out", 80'(out_q.size() - ob), 80'd0);
    apply_vec('{1, 0, 0, 1'b0, 4, 4'd9, ACK_OK_CODE, 0, 1'b1}, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
